// File: rtl/spi_rx_pkg.sv
// Shared types for the SPI packet receiver.
// States, error codes and word size used by the top and the shifter.
package spi_rx_pkg;

  localparam int SPI_WORD_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    HOLD,
    DROP
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BADLEN  = 2'd1,
    ERR_ABORT   = 2'd2,
    ERR_OVERRUN = 2'd3
  } rx_err_t;

endpackage

// File: rtl/spi_pkt_rx_if.sv
// Packet memory handle between the SPI receiver and the DPR.
// The receiver is the slave; the DPR drives reads and release.
interface spi_pkt_rx_if;

  logic        pkt_r_en;
  logic [31:0] pkt_ptr;
  logic [31:0] pkt_data_load;
  logic        pkt_done;
  logic [31:0] pkt_region_begin;
  logic [31:0] pkt_region_end;
  logic        pkt_avail;
  logic        dpr_done;

  modport slave (
    input  pkt_r_en,
    input  pkt_ptr,
    input  dpr_done,
    output pkt_data_load,
    output pkt_done,
    output pkt_region_begin,
    output pkt_region_end,
    output pkt_avail
  );

  modport master (
    output pkt_r_en,
    output pkt_ptr,
    output dpr_done,
    input  pkt_data_load,
    input  pkt_done,
    input  pkt_region_begin,
    input  pkt_region_end,
    input  pkt_avail
  );

endinterface

// File: rtl/spi_word_shifter.sv
// SPI pin synchronizers, edge detection and 32-bit word assembly.
// Emits a word_valid pulse on the rising sclk edge of bit 32.
module spi_word_shifter
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        sclk_i,
  input  logic        cs_n_i,
  input  logic        mosi_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic        cs_fall_o,
  output logic        cs_rise_o,
  output logic        cs_low_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic [31:0]            shreg_q;
  logic [4:0]             cnt_q;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   bit_en;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign bit_en = sclk_s & ~sclk_prev_q & ~cs_s;

  // cs_n resets to "low" so a frame already in flight
  // is not mistaken for a new falling edge.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      if (cs_s) begin
        cnt_q <= '0;
      end else if (bit_en) begin
        shreg_q <= word_o;
        cnt_q   <= cnt_q + 5'd1;
      end
    end
  end

  assign word_o       = {shreg_q[SPI_WORD_BITS-2:0], mosi_s};
  assign word_valid_o = bit_en & (cnt_q == 5'd31);
  assign cs_fall_o    = ~cs_s & cs_prev_q;
  assign cs_rise_o    = cs_s & ~cs_prev_q;
  assign cs_low_o     = ~cs_s;

endmodule

// File: rtl/spi_pkt_rx.sv
// SPI slave packet receiver feeding the DPR packet memory handle.
// Holds one packet until the DPR signals dpr_done.
module spi_pkt_rx
  import spi_rx_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         spi_sclk,
  input  logic         spi_cs_n,
  input  logic         spi_mosi,
  output logic         spi_miso,
  spi_pkt_rx_if.slave  pkt,
  output logic         rx_err,
  output logic [1:0]   rx_err_code
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  rx_state_t       state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            err_q, err_d;
  rx_err_t         code_q, code_d;
  logic            we;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     rdata_q;
  logic            rdone_q;
  logic            hit;

  logic            word_valid;
  logic [31:0]     word;
  logic            cs_fall;
  logic            cs_rise;
  logic            cs_low;

  spi_word_shifter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shift (
    .clk          (clk),
    .rst_l        (rst_l),
    .sclk_i       (spi_sclk),
    .cs_n_i       (spi_cs_n),
    .mosi_i       (spi_mosi),
    .word_valid_o (word_valid),
    .word_o       (word),
    .cs_fall_o    (cs_fall),
    .cs_rise_o    (cs_rise),
    .cs_low_o     (cs_low)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wr_ptr_q <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    err_d    = 1'b0;
    code_d   = code_q;
    we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) state_d = HDR;
      end
      HDR: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          code_d  = ERR_ABORT;
          state_d = IDLE;
        end else if (word_valid) begin
          if (word >= 32'd1 && word <= 32'(DEPTH)) begin
            len_d    = word[LW-1:0];
            wr_ptr_d = '0;
            state_d  = DATA;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BADLEN;
            state_d = DROP;
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          code_d  = ERR_ABORT;
          state_d = IDLE;
        end else if (word_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + LW'(1);
          if (wr_ptr_q + LW'(1) == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (cs_fall) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (pkt.dpr_done) state_d = cs_low ? DROP : IDLE;
      end
      DROP: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q[AW-1:0]] <= word;
  end

  // Reads sample the pre-release state, so a read that
  // coincides with dpr_done still returns held data.
  assign hit = (state_q == HOLD) &&
               (pkt.pkt_ptr < {{(32-LW){1'b0}}, len_q});

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rdata_q <= '0;
      rdone_q <= 1'b0;
    end else begin
      rdone_q <= pkt.pkt_r_en;
      if (pkt.pkt_r_en && hit) rdata_q <= mem[pkt.pkt_ptr[AW-1:0]];
      else                     rdata_q <= '0;
    end
  end

  assign pkt.pkt_avail        = (state_q == HOLD);
  assign pkt.pkt_region_begin = '0;
  assign pkt.pkt_region_end   = (state_q == HOLD) ?
                                {{(32-LW){1'b0}}, len_q} : '0;
  assign pkt.pkt_data_load    = rdata_q;
  assign pkt.pkt_done         = rdone_q;
  assign spi_miso             = (state_q == HOLD);
  assign rx_err               = err_q;
  assign rx_err_code          = code_q;

endmodule

// File: tb/tb_spi_pkt_rx.sv
// Directed bench for spi_pkt_rx with a frame-level packet model.
// A per-cycle compare process checks outputs against the model.
module tb_spi_pkt_rx;
  import spi_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       rx_err;
  logic [1:0] rx_err_code;

  spi_pkt_rx_if pif ();

  spi_pkt_rx #(
    .DEPTH       (32),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .spi_sclk    (sclk),
    .spi_cs_n    (cs_n),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .pkt         (pif),
    .rx_err      (rx_err),
    .rx_err_code (rx_err_code)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_buf [32];
  int          m_len = 0;
  bit          m_avail = 1'b0;
  bit          chk_avail = 1'b1;
  bit          pend = 1'b0;
  logic [31:0] pend_data = '0;
  int          err_pulses = 0;
  bit          prev_err = 1'b0;
  logic [31:0] tx [$];
  int          n0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("region_begin", pif.pkt_region_begin, 32'h0);
      if (pend) begin
        chk("rd_done", {31'b0, pif.pkt_done}, 32'd1);
        chk("rd_data", pif.pkt_data_load, pend_data);
      end else begin
        chk("rd_idle", {31'b0, pif.pkt_done}, 32'd0);
      end
      if (chk_avail) begin
        chk("avail", {31'b0, pif.pkt_avail}, {31'b0, m_avail});
        chk("miso", {31'b0, miso}, {31'b0, m_avail});
        chk("region_end", pif.pkt_region_end, m_avail ? m_len : 0);
      end
      chk("err_width", {31'b0, prev_err & rx_err}, 32'd0);
      if (rx_err) err_pulses++;
      prev_err = rx_err;
      pend = pif.pkt_r_en && rst_l;
      if (m_avail && pif.pkt_ptr < m_len)
        pend_data = m_buf[pif.pkt_ptr[4:0]];
      else
        pend_data = 32'h0;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin
      mosi = w[i];
      cyc(4);
      sclk = 1'b1;
      cyc(4);
      sclk = 1'b0;
    end
  endtask

  task automatic frame();
    cs_n = 1'b0;
    cyc(4);
    foreach (tx[i]) send_word(tx[i]);
    cyc(4);
    cs_n = 1'b1;
    cyc(12);
  endtask

  task automatic good_frame();
    chk_avail = 1'b0;
    frame();
    m_len = int'(tx[0]);
    for (int i = 0; i < m_len; i++) m_buf[i] = tx[i+1];
    m_avail = 1'b1;
    chk_avail = 1'b1;
  endtask

  task automatic read(logic [31:0] p, logic [31:0] exp, string nm);
    pif.pkt_r_en = 1'b1;
    pif.pkt_ptr  = p;
    cyc(1);
    pif.pkt_r_en = 1'b0;
    chk(nm, pif.pkt_data_load, exp);
    chk({nm, "_done"}, {31'b0, pif.pkt_done}, 32'd1);
  endtask

  task automatic release_pkt();
    pif.dpr_done = 1'b1;
    cyc(1);
    pif.dpr_done = 1'b0;
    m_avail = 1'b0;
  endtask

  task automatic err_chk(string nm, int d, logic [1:0] code);
    chk({nm, "_errs"}, err_pulses - n0, d);
    chk({nm, "_code"}, {30'b0, rx_err_code}, {30'b0, code});
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    pif.pkt_r_en = 1'b0;
    pif.pkt_ptr  = '0;
    pif.dpr_done = 1'b0;
    cyc(3);
    chk("rst_avail", {31'b0, pif.pkt_avail}, 32'd0);
    chk("rst_data", pif.pkt_data_load, 32'h0);
    chk("rst_end", pif.pkt_region_end, 32'h0);
    chk("rst_err", {31'b0, rx_err}, 32'd0);
    chk("rst_code", {30'b0, rx_err_code}, 32'd0);
    rst_l = 1'b1;
    cyc(2);

    n0 = err_pulses;
    tx = '{32'd3, 32'd1, 32'd2, 32'd3};
    good_frame();
    chk("s1_avail", {31'b0, pif.pkt_avail}, 32'd1);
    chk("s1_end", pif.pkt_region_end, 32'd3);
    read(0, 32'd1, "s1_rd0");
    read(1, 32'd2, "s1_rd1");
    read(2, 32'd3, "s1_rd2");
    for (int i = 0; i < 4; i++) begin
      pif.pkt_r_en = 1'b1;
      pif.pkt_ptr  = i;
      cyc(1);
    end
    pif.pkt_r_en = 1'b0;
    cyc(1);
    err_chk("s1", 0, 2'd0);
    release_pkt();
    read(0, 32'h0, "rd_released");

    n0 = err_pulses;
    tx = '{32'd0};
    frame();
    err_chk("badlen0", 1, 2'd1);
    tx = '{32'd33};
    frame();
    err_chk("badlen33", 2, 2'd1);
    chk("badlen_avail", {31'b0, pif.pkt_avail}, 32'd0);
    tx = '{32'd2, 32'hA5A5_0001, 32'h5A5A_0002};
    good_frame();
    read(1, 32'h5A5A_0002, "s2_rd1");
    release_pkt();

    n0 = err_pulses;
    tx = '{32'd4, 32'd11, 32'd22};
    frame();
    err_chk("abort", 1, 2'd2);
    chk("abort_avail", {31'b0, pif.pkt_avail}, 32'd0);
    tx = '{32'd2, 32'hCAFE_0000, 32'hCAFE_0001};
    good_frame();
    read(0, 32'hCAFE_0000, "s3_rd0");
    read(1, 32'hCAFE_0001, "s3_rd1");

    n0 = err_pulses;
    tx = '{32'h77};
    frame();
    err_chk("overrun", 1, 2'd3);
    chk("ovr_avail", {31'b0, pif.pkt_avail}, 32'd1);
    read(0, 32'hCAFE_0000, "ovr_rd0");
    read(1, 32'hCAFE_0001, "ovr_rd1");
    release_pkt();
    tx = '{32'd1, 32'h0BAD_F00D};
    good_frame();
    read(0, 32'h0BAD_F00D, "s4_rd0");
    release_pkt();

    n0 = err_pulses;
    tx = '{32'd1, 32'hDEAD_BEEF, 32'h0000_1234};
    good_frame();
    chk("s5_end", pif.pkt_region_end, 32'd1);
    read(0, 32'hDEAD_BEEF, "s5_rd0");
    err_chk("extra", 0, 2'd3);
    pif.pkt_r_en = 1'b1;
    pif.pkt_ptr  = 32'd1;
    pif.dpr_done = 1'b1;
    cyc(1);
    pif.pkt_r_en = 1'b0;
    pif.dpr_done = 1'b0;
    m_avail = 1'b0;
    chk("sim_data", pif.pkt_data_load, 32'h0);
    chk("sim_done", {31'b0, pif.pkt_done}, 32'd1);
    chk("sim_avail", {31'b0, pif.pkt_avail}, 32'd0);

    n0 = err_pulses;
    cs_n = 1'b0;
    cyc(4);
    send_word(32'd2);
    send_word(32'h1111);
    #2 rst_l = 1'b0;
    #1;
    chk("mid_avail", {31'b0, pif.pkt_avail}, 32'd0);
    chk("mid_code", {30'b0, rx_err_code}, 32'd0);
    chk("mid_end", pif.pkt_region_end, 32'h0);
    chk("mid_miso", {31'b0, miso}, 32'd0);
    cyc(3);
    rst_l = 1'b1;
    send_word(32'h2222);
    cyc(4);
    cs_n = 1'b1;
    cyc(12);
    err_chk("post_rst", 0, 2'd0);
    chk("post_rst_avail", {31'b0, pif.pkt_avail}, 32'd0);
    tx = '{32'd2, 32'h0000_1357, 32'h0000_2468};
    good_frame();
    read(0, 32'h0000_1357, "s6_rd0");
    read(1, 32'h0000_2468, "s6_rd1");
    release_pkt();
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
